// File: rtl/pkt_rx_buffer.sv
//==============================================================================
// Module      : pkt_rx_buffer
// Description : Store-and-forward ingress buffer; framing check, drop by
//               write-pointer rollback, committed packets out on valid/ready.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module pkt_rx_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_port,
    input  logic                     in_sop,
    input  logic                     in_eop,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_port,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [$clog2(DEPTH):0]   pkt_count,
    output logic [CNT_W-1:0]         ok_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         orphan_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam int c_LW = $clog2(MAX_WORDS + 1);

    localparam logic [c_PW-1:0] c_DEPTH   = c_PW'(DEPTH);
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);
    localparam logic [c_LW-1:0] c_MAX_LEN = c_LW'(MAX_WORDS);
    localparam logic [c_LW-1:0] c_LEN_ONE = c_LW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PW-1:0]     r_wr_ptr;
    logic [c_PW-1:0]     r_spec_ptr;
    logic [c_PW-1:0]     r_rd_ptr;
    logic [c_PW-1:0]     w_wr_nxt;
    logic [c_PW-1:0]     w_spec_nxt;
    logic [c_LW-1:0]     r_len;
    logic [c_LW-1:0]     w_len_nxt;
    logic [c_PW-1:0]     r_pkt_count;
    logic [CNT_W-1:0]    r_ok_cnt;
    logic [CNT_W-1:0]    r_drop_cnt;
    logic [CNT_W-1:0]    r_orphan_cnt;

    logic [DATA_W+1:0]   r_mem [DEPTH];
    logic [DATA_W+1:0]   w_rdata;
    logic [c_AW-1:0]     w_waddr;
    logic                w_we;
    logic                w_commit;
    logic                w_drop;
    logic                w_orphan;
    logic                w_sop_path;
    logic                w_rd;
    logic                w_full_spec;
    logic                w_full_wr;

    assign w_rdata     = r_mem[r_rd_ptr[c_AW-1:0]];
    assign out_valid   = (r_rd_ptr != r_wr_ptr);
    assign out_port    = w_rdata[DATA_W-1:0];
    assign out_eop     = w_rdata[DATA_W];
    assign out_sop     = w_rdata[DATA_W+1];
    assign w_rd        = out_valid && out_ready;
    // Occupancy uses the pre-read rd_ptr, so a read never frees space early.
    assign w_full_spec = ((r_spec_ptr - r_rd_ptr) == c_DEPTH);
    assign w_full_wr   = ((r_wr_ptr - r_rd_ptr) == c_DEPTH);

    assign pkt_count   = r_pkt_count;
    assign ok_cnt      = r_ok_cnt;
    assign drop_cnt    = r_drop_cnt;
    assign orphan_cnt  = r_orphan_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_spec_nxt  = r_spec_ptr;
        w_wr_nxt    = r_wr_ptr;
        w_len_nxt   = r_len;
        w_we        = 1'b0;
        w_waddr     = r_spec_ptr[c_AW-1:0];
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        w_orphan    = 1'b0;
        w_sop_path  = 1'b0;
        if (in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_sop) w_sop_path = 1'b1;
                    else        w_orphan   = 1'b1;
                end
                ST_RECV: begin
                    if (in_sop) begin
                        w_drop     = 1'b1;
                        w_sop_path = 1'b1;
                    end else if ((r_len == c_MAX_LEN) || w_full_spec) begin
                        w_spec_nxt  = r_wr_ptr;
                        w_drop      = 1'b1;
                        w_state_nxt = in_eop ? ST_IDLE : ST_DISCARD;
                    end else begin
                        w_we       = 1'b1;
                        w_spec_nxt = r_spec_ptr + c_PTR_ONE;
                        w_len_nxt  = r_len + c_LEN_ONE;
                        if (in_eop) begin
                            w_commit    = 1'b1;
                            w_wr_nxt    = r_spec_ptr + c_PTR_ONE;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (in_sop)      w_sop_path  = 1'b1;
                    else if (in_eop) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
            // A new packet always starts at the committed end: any open packet is rolled back.
            if (w_sop_path) begin
                if (w_full_wr) begin
                    w_drop      = 1'b1;
                    w_spec_nxt  = r_wr_ptr;
                    w_state_nxt = in_eop ? ST_IDLE : ST_DISCARD;
                end else begin
                    w_we       = 1'b1;
                    w_waddr    = r_wr_ptr[c_AW-1:0];
                    w_spec_nxt = r_wr_ptr + c_PTR_ONE;
                    w_len_nxt  = c_LEN_ONE;
                    if (in_eop) begin
                        w_commit    = 1'b1;
                        w_wr_nxt    = r_wr_ptr + c_PTR_ONE;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RECV;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= {in_sop, in_eop, in_port};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_spec_ptr   <= '0;
            r_rd_ptr     <= '0;
            r_len        <= '0;
            r_pkt_count  <= '0;
            r_ok_cnt     <= '0;
            r_drop_cnt   <= '0;
            r_orphan_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_nxt;
            r_spec_ptr <= w_spec_nxt;
            r_len      <= w_len_nxt;
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_commit, w_rd && out_eop})
                2'b10:   r_pkt_count <= r_pkt_count + c_PTR_ONE;
                2'b01:   r_pkt_count <= r_pkt_count - c_PTR_ONE;
                default: r_pkt_count <= r_pkt_count;
            endcase
            if (w_commit && (r_ok_cnt != '1))     r_ok_cnt     <= r_ok_cnt + 1'b1;
            if (w_drop && (r_drop_cnt != '1))     r_drop_cnt   <= r_drop_cnt + 1'b1;
            if (w_orphan && (r_orphan_cnt != '1)) r_orphan_cnt <= r_orphan_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pkt_rx_buffer.sv
//==============================================================================
// Module      : tb_pkt_rx_buffer
// Description : Scoreboard bench for pkt_rx_buffer with a packet-level model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pkt_rx_buffer;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 64;
    localparam int MAX_WORDS = 16;
    localparam int CNT_W     = 16;
    localparam int PW        = $clog2(DEPTH) + 1;

    typedef logic [DATA_W+1:0] word_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_sop, in_eop;
    logic [DATA_W-1:0] in_port;
    logic              out_valid, out_ready, out_sop, out_eop;
    logic [DATA_W-1:0] out_port;
    logic [PW-1:0]     pkt_count;
    logic [CNT_W-1:0]  ok_cnt, drop_cnt, orphan_cnt;

    pkt_rx_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_port(in_port), .in_sop(in_sop), .in_eop(in_eop),
        .out_valid(out_valid), .out_ready(out_ready), .out_port(out_port),
        .out_sop(out_sop), .out_eop(out_eop), .pkt_count(pkt_count),
        .ok_cnt(ok_cnt), .drop_cnt(drop_cnt), .orphan_cnt(orphan_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: committed words, the open packet, and the expected output stream.
    word_t exp_q[$];
    word_t mdl_q[$];
    word_t cur_q[$];
    bit    in_pkt, discarding;
    int    m_ok, m_drop, m_orphan, m_pkts;

    int    n_cmp = 0, n_err = 0, out_words = 0;
    bit    rdy_rand = 1'b0;
    logic  rdy_fix = 1'b1;
    bit    gap_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit    rd, full_pre, commit;
        word_t w;
        rd       = (mdl_q.size() > 0) && out_ready;
        full_pre = ((mdl_q.size() + cur_q.size()) == DEPTH);
        commit   = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                if (in_pkt) begin
                    m_drop++;
                    cur_q.delete();
                    in_pkt = 1'b0;
                end
                discarding = 1'b0;
                if (mdl_q.size() == DEPTH) begin
                    m_drop++;
                    discarding = !in_eop;
                end else begin
                    cur_q.push_back({1'b1, in_eop, in_port});
                    if (in_eop) commit = 1'b1;
                    else        in_pkt = 1'b1;
                end
            end else if (in_pkt) begin
                if (cur_q.size() == MAX_WORDS || full_pre) begin
                    m_drop++;
                    cur_q.delete();
                    in_pkt     = 1'b0;
                    discarding = !in_eop;
                end else begin
                    cur_q.push_back({1'b0, in_eop, in_port});
                    if (in_eop) commit = 1'b1;
                end
            end else if (discarding) begin
                if (in_eop) discarding = 1'b0;
            end else begin
                m_orphan++;
            end
        end
        if (commit) begin
            foreach (cur_q[i]) begin
                mdl_q.push_back(cur_q[i]);
                exp_q.push_back(cur_q[i]);
            end
            cur_q.delete();
            in_pkt = 1'b0;
            m_ok++;
            m_pkts++;
        end
        if (rd) begin
            w = mdl_q.pop_front();
            if (w[DATA_W]) m_pkts--;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_q.delete(); mdl_q.delete(); cur_q.delete();
                in_pkt = 1'b0; discarding = 1'b0;
                m_ok = 0; m_drop = 0; m_orphan = 0; m_pkts = 0;
            end else begin
                model_step();
            end
        end
    end

    // Monitor: observes the DUT mid-cycle and pops the scoreboard on each transfer.
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            check("out_valid", out_valid, (mdl_q.size() > 0));
            check("pkt_count", pkt_count, m_pkts);
            check("ok_cnt", ok_cnt, m_ok);
            check("drop_cnt", drop_cnt, m_drop);
            check("orphan_cnt", orphan_cnt, m_orphan);
            if (out_valid && out_ready) begin
                out_words++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {out_sop, out_eop, out_port}, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {out_sop, out_eop, out_port}, e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom) : rdy_fix;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input bit sop, input bit eop, input logic [DATA_W-1:0] d);
        if (gap_en && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0; in_sop = 1'($urandom); in_eop = 1'($urandom); in_port = $urandom;
            idle(1);
        end
        in_valid = 1'b1; in_sop = sop; in_eop = eop; in_port = d;
        idle(1);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic send_pkt(input int n, input bit with_eop);
        for (int i = 0; i < n; i++) beat(i == 0, with_eop && (i == n - 1), $urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (mdl_q.size() != 0 && k < 3000) begin
            idle(1);
            k++;
        end
        check(name, mdl_q.size(), 0);
        idle(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, tot, r;
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_port = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_pkt_count", pkt_count, 0);
        rst = 1'b0;
        idle(2);

        // Basic 4-word packet and commit latency
        rdy_fix = 1'b1;
        idle(2);
        base = out_words;
        beat(1'b1, 1'b0, 32'h1111_0000);
        beat(1'b0, 1'b0, 32'h1111_0001);
        beat(1'b0, 1'b0, 32'h1111_0002);
        check("t1_no_early_valid", out_valid, 0);
        beat(1'b0, 1'b1, 32'h1111_0003);
        check("t1_latency", out_valid, 1);
        idle(8);
        check("t1_words", out_words - base, 4);
        check("t1_ok_cnt", ok_cnt, 1);
        check("t1_pkt_count", pkt_count, 0);

        // Single-word packet then orphan
        do_reset();
        base = out_words;
        beat(1'b1, 1'b1, 32'hCAFE_0001);
        beat(1'b0, 1'b0, 32'hDEAD_0002);
        idle(5);
        check("t2_words", out_words - base, 1);
        check("t2_orphan", orphan_cnt, 1);
        check("t2_ok", ok_cnt, 1);

        // Oversize packet, then a good one
        do_reset();
        send_pkt(MAX_WORDS + 1, 1'b1);
        check("t3_drop", drop_cnt, 1);
        check("t3_no_valid", out_valid, 0);
        base = out_words;
        send_pkt(2, 1'b1);
        idle(6);
        check("t3_ok", ok_cnt, 1);
        check("t3_words", out_words - base, 2);

        // Missing eop aborted by a new sop
        do_reset();
        base = out_words;
        send_pkt(3, 1'b0);
        send_pkt(2, 1'b1);
        idle(6);
        check("t4_drop", drop_cnt, 1);
        check("t4_ok", ok_cnt, 1);
        check("t4_words", out_words - base, 2);

        // Fill, overflow, drain, and wrap
        do_reset();
        rdy_fix = 1'b0;
        idle(2);
        repeat (4) send_pkt(16, 1'b1);
        idle(2);
        check("t5_full_pkts", pkt_count, 4);
        send_pkt(16, 1'b1);
        idle(2);
        check("t5_drop", drop_cnt, 1);
        check("t5_pkts_after_drop", pkt_count, 4);
        base = out_words;
        rdy_fix = 1'b1;
        drain("t5_drain_full");
        check("t5_words", out_words - base, 64);
        tot = 0;
        base = out_words;
        for (int p = 0; p < 20; p++) begin
            r = $urandom_range(5, 16);
            tot += r;
            send_pkt(r, 1'b1);
        end
        drain("t5_drain_wrap");
        check("t5_wrap_ok", ok_cnt, 24);
        check("t5_wrap_words", out_words - base, tot);

        // Reset mid-packet with committed data held
        do_reset();
        rdy_fix = 1'b0;
        idle(2);
        send_pkt(3, 1'b1);
        send_pkt(3, 1'b1);
        send_pkt(2, 1'b0);
        check("t6_pkts_before", pkt_count, 2);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_pkts", pkt_count, 0);
        idle(1);
        rst = 1'b0;
        rdy_fix = 1'b1;
        idle(2);
        base = out_words;
        send_pkt(4, 1'b1);
        send_pkt(1, 1'b1);
        drain("t6_drain");
        check("t6_ok", ok_cnt, 2);
        check("t6_words", out_words - base, 5);

        // Randomized traffic with gaps and back-pressure
        do_reset();
        gap_en = 1'b1;
        rdy_rand = 1'b1;
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      send_pkt($urandom_range(1, MAX_WORDS), 1'b1);
            else if (r < 72) send_pkt($urandom_range(MAX_WORDS + 1, MAX_WORDS + 3), 1'b1);
            else if (r < 82) send_pkt($urandom_range(1, 4), 1'b0);
            else if (r < 92) beat(1'b0, 1'($urandom), $urandom);
            else             idle($urandom_range(1, 5));
        end
        gap_en = 1'b0;
        rdy_rand = 1'b0;
        rdy_fix = 1'b1;
        drain("t7_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
